// File: rtl/vx_tl_pkg.sv
// vx_tl_pkg: shared definitions for the Vortex dcache to TileLink-UL lane adapter.
//   - TileLink A/D opcode constants
//   - slot_state_e: per-slot life cycle
//   - lsb_index(): lowest-set-bit priority pick, used for slot allocation and
//     response selection (vectors up to 32 bits)
package vx_tl_pkg;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    SLOT_FREE,
    SLOT_PEND,
    SLOT_DONE
  } slot_state_e;

  function automatic int unsigned lsb_index(input logic [31:0] vec);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vx_tl_slot_table.sv
// vx_tl_slot_table: outstanding-request tracking for vx_tl_lane_adapter.
// Holds NUM_SLOTS entries (tag, issued mask, read mask, received mask, lane
// data), allocates the lowest FREE slot, absorbs D beats on every lane in the
// same cycle, and picks the lowest DONE slot with read data for the response
// register. A slot completing this cycle is already visible to the pick so the
// response register can load on the same edge as the last beat.
//
//   state | meaning
//   FREE  | unused, allocatable
//   PEND  | issued, waiting for D beats on its issued lanes
//   DONE  | all beats in, waiting for its core response to be accepted
//
// Ports: clock/reset_n; alloc_* (issue side); free_any/free_idx (allocation
// pick); d_* (D channel beats); d_err (stray/denied/corrupt pulse);
// hold_valid/hold_idx/release_hold (slot owned by the response register);
// pick_* (response candidate). With VX_TL_ADAPTER_PERF_EN defined, busy_cnt
// reports the number of non-FREE slots.
module vx_tl_slot_table
  import vx_tl_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 10,
  parameter int NUM_SLOTS  = 8,
  localparam int SRC_WIDTH = $clog2(NUM_SLOTS)
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  alloc,
  input  logic [TAG_WIDTH-1:0]                  alloc_tag,
  input  logic [NUM_LANES-1:0]                  alloc_mask,
  input  logic [NUM_LANES-1:0]                  alloc_rmask,
  output logic                                  free_any,
  output logic [SRC_WIDTH-1:0]                  free_idx,
  input  logic [NUM_LANES-1:0]                  d_valid,
  input  logic [NUM_LANES-1:0][2:0]             d_opcode,
  input  logic [NUM_LANES-1:0][SRC_WIDTH-1:0]   d_source,
  input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  d_data,
  input  logic [NUM_LANES-1:0]                  d_denied,
  input  logic [NUM_LANES-1:0]                  d_corrupt,
  output logic                                  d_err,
  input  logic                                  hold_valid,
  input  logic [SRC_WIDTH-1:0]                  hold_idx,
  input  logic                                  release_hold,
  output logic                                  pick_valid,
  output logic [SRC_WIDTH-1:0]                  pick_idx,
  output logic [TAG_WIDTH-1:0]                  pick_tag,
  output logic [NUM_LANES-1:0]                  pick_rmask,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  pick_data
`ifdef VX_TL_ADAPTER_PERF_EN
  , output logic [SRC_WIDTH:0]                  busy_cnt
`endif
);

  slot_state_e                           state_q  [NUM_SLOTS];
  logic [TAG_WIDTH-1:0]                  tag_q    [NUM_SLOTS];
  logic [NUM_LANES-1:0]                  issued_q [NUM_SLOTS];
  logic [NUM_LANES-1:0]                  rmask_q  [NUM_SLOTS];
  logic [NUM_LANES-1:0]                  recv_q   [NUM_SLOTS];
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  data_q   [NUM_SLOTS];

  logic [NUM_LANES-1:0]                  recv_nxt [NUM_SLOTS];
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  data_nxt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]                  completing;
  logic [NUM_SLOTS-1:0]                  free_vec;
  logic [NUM_SLOTS-1:0]                  cand_vec;

  always_comb begin
    d_err = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      recv_nxt[s] = recv_q[s];
      data_nxt[s] = data_q[s];
    end
    // Each lane is absorbed independently; a beat is only accepted by a PEND
    // slot that has not yet seen that lane, anything else is stray.
    for (int l = 0; l < NUM_LANES; l++) begin
      if (d_valid[l]) begin
        if (state_q[d_source[l]] == SLOT_PEND && !recv_q[d_source[l]][l]) begin
          recv_nxt[d_source[l]][l] = 1'b1;
          if (d_opcode[l] == TL_ACCESS_ACK_DATA) begin
            data_nxt[d_source[l]][l] = d_data[l];
          end
        end else begin
          d_err = 1'b1;
        end
        if (d_denied[l] || d_corrupt[l]) begin
          d_err = 1'b1;
        end
      end
    end
    for (int s = 0; s < NUM_SLOTS; s++) begin
      free_vec[s]   = (state_q[s] == SLOT_FREE);
      completing[s] = (state_q[s] == SLOT_PEND) && (recv_nxt[s] == issued_q[s]);
      cand_vec[s]   = ((state_q[s] == SLOT_DONE) || (completing[s] && (|rmask_q[s])))
                      && !(hold_valid && hold_idx == SRC_WIDTH'(s));
    end
    free_any   = |free_vec;
    free_idx   = SRC_WIDTH'(lsb_index(32'(free_vec)));
    pick_valid = |cand_vec;
    pick_idx   = SRC_WIDTH'(lsb_index(32'(cand_vec)));
    pick_tag   = tag_q[pick_idx];
    pick_rmask = rmask_q[pick_idx];
    pick_data  = data_nxt[pick_idx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s]  <= SLOT_FREE;
        tag_q[s]    <= '0;
        issued_q[s] <= '0;
        rmask_q[s]  <= '0;
        recv_q[s]   <= '0;
        data_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (alloc && free_idx == SRC_WIDTH'(s)) begin
          state_q[s]  <= SLOT_PEND;
          tag_q[s]    <= alloc_tag;
          issued_q[s] <= alloc_mask;
          rmask_q[s]  <= alloc_rmask;
          recv_q[s]   <= '0;
          data_q[s]   <= '0;
        end else if (state_q[s] == SLOT_PEND) begin
          recv_q[s] <= recv_nxt[s];
          data_q[s] <= data_nxt[s];
          if (completing[s]) begin
            // write-only requests have nothing to return and retire at once
            state_q[s] <= (|rmask_q[s]) ? SLOT_DONE : SLOT_FREE;
          end
        end else if (state_q[s] == SLOT_DONE && release_hold && hold_idx == SRC_WIDTH'(s)) begin
          state_q[s] <= SLOT_FREE;
        end
      end
    end
  end

`ifdef VX_TL_ADAPTER_PERF_EN
  always_comb begin
    busy_cnt = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (state_q[s] != SLOT_FREE) begin
        busy_cnt = busy_cnt + (SRC_WIDTH+1)'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/vx_tl_lane_adapter.sv
// vx_tl_lane_adapter: Vortex dcache request/response port to NUM_LANES
// independent TileLink-UL channels, with up to NUM_SLOTS outstanding requests.
// TileLink source carries the slot index.
//
// Ports: clock, reset_n (async, active-low); core_req_* (per-lane request,
// shared tag, all-or-nothing issue); core_rsp_* (registered response);
// tl_a_* (A channel per lane); tl_d_* (D channel per lane, always ready once
// out of reset); err_sticky (stray, duplicate, denied or corrupt beat seen).
// Optional: define VX_TL_ADAPTER_PERF_EN to add perf_reqs, perf_stalls and
// perf_max_occ saturating counters.
module vx_tl_lane_adapter
  import vx_tl_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 10,
  parameter int NUM_SLOTS  = 8,
  localparam int SRC_WIDTH = $clog2(NUM_SLOTS),
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int OFS       = $clog2(BYTES),
  localparam int WADDR     = ADDR_WIDTH - OFS
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_LANES-1:0]              core_req_valid,
  input  logic [NUM_LANES-1:0]              core_req_rw,
  input  logic [NUM_LANES*BYTES-1:0]        core_req_byteen,
  input  logic [NUM_LANES*WADDR-1:0]        core_req_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   core_req_data,
  input  logic [TAG_WIDTH-1:0]              core_req_tag,
  output logic [NUM_LANES-1:0]              core_req_ready,
  output logic                              core_rsp_valid,
  output logic [NUM_LANES-1:0]              core_rsp_tmask,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   core_rsp_data,
  output logic [TAG_WIDTH-1:0]              core_rsp_tag,
  input  logic                              core_rsp_ready,
  output logic [NUM_LANES-1:0]              tl_a_valid,
  input  logic [NUM_LANES-1:0]              tl_a_ready,
  output logic [3*NUM_LANES-1:0]            tl_a_opcode,
  output logic [4*NUM_LANES-1:0]            tl_a_size,
  output logic [SRC_WIDTH*NUM_LANES-1:0]    tl_a_source,
  output logic [ADDR_WIDTH*NUM_LANES-1:0]   tl_a_address,
  output logic [BYTES*NUM_LANES-1:0]        tl_a_mask,
  output logic [DATA_WIDTH*NUM_LANES-1:0]   tl_a_data,
  input  logic [NUM_LANES-1:0]              tl_d_valid,
  input  logic [3*NUM_LANES-1:0]            tl_d_opcode,
  input  logic [SRC_WIDTH*NUM_LANES-1:0]    tl_d_source,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]   tl_d_data,
  input  logic [NUM_LANES-1:0]              tl_d_denied,
  input  logic [NUM_LANES-1:0]              tl_d_corrupt,
  output logic [NUM_LANES-1:0]              tl_d_ready,
  output logic                              err_sticky
`ifdef VX_TL_ADAPTER_PERF_EN
  , output logic [31:0]                     perf_reqs
  , output logic [31:0]                     perf_stalls
  , output logic [SRC_WIDTH:0]              perf_max_occ
`endif
);

  logic                                 run_q;
  logic                                 free_any;
  logic [SRC_WIDTH-1:0]                 free_idx;
  logic                                 accept;
  logic                                 fire;
  logic                                 d_err;
  logic                                 pick_valid;
  logic [SRC_WIDTH-1:0]                 pick_idx;
  logic [TAG_WIDTH-1:0]                 pick_tag;
  logic [NUM_LANES-1:0]                 pick_rmask;
  logic [NUM_LANES*DATA_WIDTH-1:0]      pick_data;
  logic [SRC_WIDTH-1:0]                 rsp_slot_q;
  logic                                 rsp_load;
  logic                                 rsp_release;
`ifdef VX_TL_ADAPTER_PERF_EN
  logic [SRC_WIDTH:0]                   busy_cnt;
`endif

  // run_q keeps the core and D handshakes closed while reset is asserted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Issue is atomic: every requesting lane must be accepted by TileLink.
  assign accept         = run_q && free_any && (&(tl_a_ready | ~core_req_valid));
  assign fire           = accept && (|core_req_valid);
  assign core_req_ready = {NUM_LANES{accept}};
  assign tl_a_valid     = fire ? core_req_valid : '0;
  assign tl_a_mask      = core_req_byteen;
  assign tl_a_data      = core_req_data;
  assign tl_d_ready     = {NUM_LANES{run_q}};

  always_comb begin
    tl_a_opcode  = '0;
    tl_a_size    = '0;
    tl_a_source  = '0;
    tl_a_address = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (!core_req_rw[l])                        tl_a_opcode[l*3 +: 3] = TL_GET;
      else if (&core_req_byteen[l*BYTES +: BYTES]) tl_a_opcode[l*3 +: 3] = TL_PUT_FULL;
      else                                        tl_a_opcode[l*3 +: 3] = TL_PUT_PARTIAL;
      tl_a_size[l*4 +: 4]                     = 4'(OFS);
      tl_a_source[l*SRC_WIDTH +: SRC_WIDTH]   = free_idx;
      tl_a_address[l*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(core_req_addr[l*WADDR +: WADDR]) << OFS;
    end
  end

  vx_tl_slot_table #(
    .NUM_LANES  (NUM_LANES),
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_slots (
    .clock        (clock),
    .reset_n      (reset_n),
    .alloc        (fire),
    .alloc_tag    (core_req_tag),
    .alloc_mask   (core_req_valid),
    .alloc_rmask  (core_req_valid & ~core_req_rw),
    .free_any     (free_any),
    .free_idx     (free_idx),
    .d_valid      (tl_d_valid & {NUM_LANES{run_q}}),
    .d_opcode     (tl_d_opcode),
    .d_source     (tl_d_source),
    .d_data       (tl_d_data),
    .d_denied     (tl_d_denied),
    .d_corrupt    (tl_d_corrupt),
    .d_err        (d_err),
    .hold_valid   (core_rsp_valid),
    .hold_idx     (rsp_slot_q),
    .release_hold (rsp_release),
    .pick_valid   (pick_valid),
    .pick_idx     (pick_idx),
    .pick_tag     (pick_tag),
    .pick_rmask   (pick_rmask),
    .pick_data    (pick_data)
`ifdef VX_TL_ADAPTER_PERF_EN
    , .busy_cnt   (busy_cnt)
`endif
  );

  // The slot stays DONE while its response sits in the register; it is only
  // released when the core accepts, so a refill on accept gives 1 rsp/cycle.
  assign rsp_release = core_rsp_valid && core_rsp_ready;
  assign rsp_load    = pick_valid && (!core_rsp_valid || core_rsp_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_rsp_valid <= 1'b0;
      core_rsp_tmask <= '0;
      core_rsp_data  <= '0;
      core_rsp_tag   <= '0;
      rsp_slot_q     <= '0;
      err_sticky     <= 1'b0;
    end else begin
      if (rsp_load) begin
        core_rsp_valid <= 1'b1;
        core_rsp_tmask <= pick_rmask;
        core_rsp_data  <= pick_data;
        core_rsp_tag   <= pick_tag;
        rsp_slot_q     <= pick_idx;
      end else if (rsp_release) begin
        core_rsp_valid <= 1'b0;
      end
      if (d_err) err_sticky <= 1'b1;
    end
  end

`ifdef VX_TL_ADAPTER_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_reqs    <= '0;
      perf_stalls  <= '0;
      perf_max_occ <= '0;
    end else begin
      if (fire && perf_reqs != '1) perf_reqs <= perf_reqs + 32'd1;
      if ((|core_req_valid) && !accept && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
      if (busy_cnt > perf_max_occ) perf_max_occ <= busy_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_vx_tl_lane_adapter.sv
module tb_vx_tl_lane_adapter;

  logic          clock;
  logic          reset_n;
  logic [3:0]    core_req_valid;
  logic [3:0]    core_req_rw;
  logic [15:0]   core_req_byteen;
  logic [119:0]  core_req_addr;
  logic [127:0]  core_req_data;
  logic [9:0]    core_req_tag;
  logic [3:0]    core_req_ready;
  logic          core_rsp_valid;
  logic [3:0]    core_rsp_tmask;
  logic [127:0]  core_rsp_data;
  logic [9:0]    core_rsp_tag;
  logic          core_rsp_ready;
  logic [3:0]    tl_a_valid;
  logic [3:0]    tl_a_ready;
  logic [11:0]   tl_a_opcode;
  logic [15:0]   tl_a_size;
  logic [11:0]   tl_a_source;
  logic [127:0]  tl_a_address;
  logic [15:0]   tl_a_mask;
  logic [127:0]  tl_a_data;
  logic [3:0]    tl_d_valid;
  logic [11:0]   tl_d_opcode;
  logic [11:0]   tl_d_source;
  logic [127:0]  tl_d_data;
  logic [3:0]    tl_d_denied;
  logic [3:0]    tl_d_corrupt;
  logic [3:0]    tl_d_ready;
  logic          err_sticky;

  int checks = 0;
  int errors = 0;

  vx_tl_lane_adapter dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .core_req_valid  (core_req_valid),
    .core_req_rw     (core_req_rw),
    .core_req_byteen (core_req_byteen),
    .core_req_addr   (core_req_addr),
    .core_req_data   (core_req_data),
    .core_req_tag    (core_req_tag),
    .core_req_ready  (core_req_ready),
    .core_rsp_valid  (core_rsp_valid),
    .core_rsp_tmask  (core_rsp_tmask),
    .core_rsp_data   (core_rsp_data),
    .core_rsp_tag    (core_rsp_tag),
    .core_rsp_ready  (core_rsp_ready),
    .tl_a_valid      (tl_a_valid),
    .tl_a_ready      (tl_a_ready),
    .tl_a_opcode     (tl_a_opcode),
    .tl_a_size       (tl_a_size),
    .tl_a_source     (tl_a_source),
    .tl_a_address    (tl_a_address),
    .tl_a_mask       (tl_a_mask),
    .tl_a_data       (tl_a_data),
    .tl_d_valid      (tl_d_valid),
    .tl_d_opcode     (tl_d_opcode),
    .tl_d_source     (tl_d_source),
    .tl_d_data       (tl_d_data),
    .tl_d_denied     (tl_d_denied),
    .tl_d_corrupt    (tl_d_corrupt),
    .tl_d_ready      (tl_d_ready),
    .err_sticky      (err_sticky)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic d_beat(input int l, input logic [2:0] src, input logic [2:0] op,
                        input logic [31:0] data, input logic den);
    tl_d_valid[l]          = 1'b1;
    tl_d_source[l*3 +: 3]  = src;
    tl_d_opcode[l*3 +: 3]  = op;
    tl_d_data[l*32 +: 32]  = data;
    tl_d_denied[l]         = den;
  endtask

  task automatic d_clear();
    tl_d_valid   = '0;
    tl_d_source  = '0;
    tl_d_opcode  = '0;
    tl_d_data    = '0;
    tl_d_denied  = '0;
    tl_d_corrupt = '0;
  endtask

  task automatic set_addr(input logic [29:0] base);
    for (int l = 0; l < 4; l++) core_req_addr[l*30 +: 30] = base + 30'(l);
  endtask

  initial begin
    reset_n         = 1'b0;
    core_req_valid  = 4'hF;
    core_req_rw     = '0;
    core_req_byteen = 16'hFFFF;
    core_req_addr   = '0;
    core_req_data   = '0;
    core_req_tag    = '0;
    core_rsp_ready  = 1'b1;
    tl_a_ready      = 4'hF;
    d_clear();
    tick();
    tick();
    chk("rst_req_ready", 128'(core_req_ready), 128'h0);
    chk("rst_a_valid",   128'(tl_a_valid),     128'h0);
    chk("rst_rsp_valid", 128'(core_rsp_valid), 128'h0);
    chk("rst_err",       128'(err_sticky),     128'h0);
    chk("rst_d_ready",   128'(tl_d_ready),     128'h0);
    core_req_valid = '0;
    reset_n = 1'b1;
    tick();
    tick();

    // all-lane read, D returns lanes 3,1,0,2
    core_req_valid = 4'hF;
    core_req_rw    = 4'h0;
    set_addr(30'h100);
    core_req_tag   = 10'h2A;
    #1;
    chk("rd_ready",   128'(core_req_ready), 128'hF);
    chk("rd_a_valid", 128'(tl_a_valid),     128'hF);
    chk("rd_addr",    tl_a_address, 128'h0000040C_00000408_00000404_00000400);
    chk("rd_opcode",  128'(tl_a_opcode), 128'h924);
    chk("rd_source",  128'(tl_a_source), 128'h000);
    chk("rd_size",    128'(tl_a_size),   128'h2222);
    tick();
    core_req_valid = '0;
    d_beat(3, 3'd0, 3'd1, 32'hA3, 1'b0); tick(); d_clear();
    d_beat(1, 3'd0, 3'd1, 32'hA1, 1'b0); tick(); d_clear();
    d_beat(0, 3'd0, 3'd1, 32'hA0, 1'b0); tick(); d_clear();
    d_beat(2, 3'd0, 3'd1, 32'hA2, 1'b0);
    #1;
    chk("rd_rsp_early", 128'(core_rsp_valid), 128'h0);
    tick();
    d_clear();
    chk("rd_rsp_valid", 128'(core_rsp_valid), 128'h1);
    chk("rd_rsp_tag",   128'(core_rsp_tag),   128'h2A);
    chk("rd_rsp_tmask", 128'(core_rsp_tmask), 128'hF);
    chk("rd_rsp_data",  core_rsp_data, 128'h000000A3_000000A2_000000A1_000000A0);
    tick();
    chk("rd_rsp_drop",  128'(core_rsp_valid), 128'h0);

    // mixed: lanes 0,1 write (full, partial), lanes 2,3 read
    core_req_valid  = 4'hF;
    core_req_rw     = 4'b0011;
    core_req_byteen = 16'hFF3F;
    set_addr(30'h200);
    core_req_tag    = 10'h155;
    #1;
    chk("mx_opcode", 128'(tl_a_opcode), 128'h908);
    chk("mx_source", 128'(tl_a_source), 128'h000);
    chk("mx_mask",   128'(tl_a_mask),   128'hFF3F);
    tick();
    core_req_valid  = '0;
    core_req_byteen = 16'hFFFF;
    d_beat(2, 3'd0, 3'd1, 32'hB2, 1'b0);
    d_beat(3, 3'd0, 3'd1, 32'hB3, 1'b0);
    tick(); d_clear();
    d_beat(0, 3'd0, 3'd0, 32'h0, 1'b0);
    tick(); d_clear();
    chk("mx_rsp_wait", 128'(core_rsp_valid), 128'h0);
    d_beat(1, 3'd0, 3'd0, 32'h0, 1'b0);
    tick(); d_clear();
    chk("mx_rsp_valid", 128'(core_rsp_valid), 128'h1);
    chk("mx_rsp_tmask", 128'(core_rsp_tmask), 128'hC);
    chk("mx_rsp_tag",   128'(core_rsp_tag),   128'h155);
    chk("mx_rsp_data",  core_rsp_data, 128'h000000B3_000000B2_00000000_00000000);
    tick();
    chk("mx_rsp_drop",  128'(core_rsp_valid), 128'h0);

    // write-only: no response, slot back the next cycle
    core_req_valid = 4'hF;
    core_req_rw    = 4'hF;
    core_req_tag   = 10'h0AB;
    #1;
    chk("wr_opcode", 128'(tl_a_opcode), 128'h000);
    tick();
    core_req_valid = '0;
    core_req_rw    = '0;
    for (int l = 0; l < 4; l++) d_beat(l, 3'd0, 3'd0, 32'h0, 1'b0);
    tick(); d_clear();
    chk("wr_no_rsp", 128'(core_rsp_valid), 128'h0);

    // fill all 8 slots, one lane each
    for (int i = 0; i < 8; i++) begin
      core_req_valid = 4'(1 << (i % 4));
      core_req_tag   = 10'(10'h300 + i);
      set_addr(30'(30'h1000 + 16 * i));
      #1;
      chk("fill_ready",  128'(core_req_ready), 128'hF);
      chk("fill_source", 128'(tl_a_source[(i % 4) * 3 +: 3]), 128'(i));
      tick();
    end
    core_req_valid = 4'b0010;
    core_req_tag   = 10'h3FF;
    #1;
    chk("full_ready",   128'(core_req_ready), 128'h0);
    chk("full_a_valid", 128'(tl_a_valid),     128'h0);
    d_beat(1, 3'd5, 3'd1, 32'hC5, 1'b0);
    tick(); d_clear();
    chk("full_rsp_valid", 128'(core_rsp_valid), 128'h1);
    chk("full_rsp_tag",   128'(core_rsp_tag),   128'h305);
    chk("full_rsp_data",  core_rsp_data, 128'h00000000_00000000_000000C5_00000000);
    chk("full_still",     128'(core_req_ready), 128'h0);
    tick();
    chk("full_reopen",    128'(core_req_ready), 128'hF);
    chk("full_reuse_src", 128'(tl_a_source[5:3]), 128'h5);
    chk("full_a_valid2",  128'(tl_a_valid), 128'h2);
    tick();
    core_req_valid = '0;
    #1;
    chk("full_again", 128'(core_req_ready), 128'h0);

    // backpressure: slots 2 and 7 complete together
    core_rsp_ready = 1'b0;
    d_beat(2, 3'd2, 3'd1, 32'hD2, 1'b0);
    d_beat(3, 3'd7, 3'd1, 32'hD7, 1'b0);
    tick(); d_clear();
    chk("bp_valid", 128'(core_rsp_valid), 128'h1);
    chk("bp_tag",   128'(core_rsp_tag),   128'h302);
    chk("bp_tmask", 128'(core_rsp_tmask), 128'h4);
    chk("bp_data",  core_rsp_data, 128'h00000000_000000D2_00000000_00000000);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", 128'(core_rsp_valid), 128'h1);
      chk("bp_hold_tag",   128'(core_rsp_tag),   128'h302);
    end
    core_rsp_ready = 1'b1;
    tick();
    chk("bp_next_valid", 128'(core_rsp_valid), 128'h1);
    chk("bp_next_tag",   128'(core_rsp_tag),   128'h307);
    chk("bp_next_tmask", 128'(core_rsp_tmask), 128'h8);
    chk("bp_next_data",  core_rsp_data, 128'h000000D7_00000000_00000000_00000000);
    tick();
    chk("bp_empty", 128'(core_rsp_valid), 128'h0);

    // denied beat still completes slot 0 and sets err_sticky
    chk("err_clear", 128'(err_sticky), 128'h0);
    d_beat(0, 3'd0, 3'd1, 32'hE0, 1'b1);
    tick(); d_clear();
    chk("den_err",      128'(err_sticky),     128'h1);
    chk("den_rsp",      128'(core_rsp_valid), 128'h1);
    chk("den_rsp_tag",  128'(core_rsp_tag),   128'h300);
    chk("den_rsp_data", core_rsp_data, 128'h00000000_00000000_00000000_000000E0);
    tick();
    chk("den_err_hold", 128'(err_sticky),     128'h1);
    chk("den_rsp_drop", 128'(core_rsp_valid), 128'h0);

    // async reset with a response held and a request pending
    core_rsp_ready = 1'b0;
    d_beat(1, 3'd1, 3'd1, 32'hF1, 1'b0);
    tick(); d_clear();
    chk("mid_rsp_tag", 128'(core_rsp_tag), 128'h301);
    core_req_valid = 4'hF;
    #1;
    chk("mid_ready", 128'(core_req_ready), 128'hF);
    reset_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 128'(core_rsp_valid), 128'h0);
    chk("arst_err",       128'(err_sticky),     128'h0);
    chk("arst_ready",     128'(core_req_ready), 128'h0);
    chk("arst_a_valid",   128'(tl_a_valid),     128'h0);
    chk("arst_d_ready",   128'(tl_d_ready),     128'h0);
    core_req_valid = '0;
    core_rsp_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_d_ready", 128'(tl_d_ready),     128'hF);
    chk("post_ready",   128'(core_req_ready), 128'hF);
    chk("post_err",     128'(err_sticky),     128'h0);

    // stray beat to a FREE slot
    d_beat(0, 3'd3, 3'd1, 32'h55, 1'b0);
    tick(); d_clear();
    chk("stray_err", 128'(err_sticky),     128'h1);
    chk("stray_rsp", 128'(core_rsp_valid), 128'h0);
    tick();
    tick();
    tick();
    chk("stray_err_hold", 128'(err_sticky), 128'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_tl_lane_adapter.md
Name: vx_tl_lane_adapter

Overview:
- Bridges the Vortex core dcache request/response interface to NUM_LANES independent TileLink-UL lane channels.
- Successor to the fixed 4-lane pass-through adapter, which shares one tag across lanes and has no tracking.
- Adds a slot table for up to NUM_SLOTS outstanding requests, per-lane response gathering, write-ack retirement and a registered core response port.
- Sits between VX_pipeline dcache ports and the tile's per-lane dmem TileLink nodes.

Parameters:
NUM_LANES, 4, number of lanes / TileLink channels
DATA_WIDTH, 32, bits per lane word (power of two, >= 8)
ADDR_WIDTH, 32, TileLink byte-address width
TAG_WIDTH, 10, core request tag width
NUM_SLOTS, 8, outstanding core requests (power of two, >= 2); TileLink source = slot index, SRC_WIDTH = log2(NUM_SLOTS)

Ports:
clock  in  1  clock
reset_n  in  1  reset
core_req_valid  in  NUM_LANES  per-lane request valid
core_req_rw  in  NUM_LANES  1 = write
core_req_byteen  in  NUM_LANES*DATA_WIDTH/8  byte enables
core_req_addr  in  NUM_LANES*(ADDR_WIDTH-OFS)  word addresses, OFS = log2(DATA_WIDTH/8)
core_req_data  in  NUM_LANES*DATA_WIDTH  write data
core_req_tag  in  TAG_WIDTH  request tag, shared by all lanes
core_req_ready  out  NUM_LANES  per-lane ready, all bits equal
core_rsp_valid  out  1  response valid
core_rsp_tmask  out  NUM_LANES  lanes carrying read data
core_rsp_data  out  NUM_LANES*DATA_WIDTH  read data
core_rsp_tag  out  TAG_WIDTH  original tag
core_rsp_ready  in  1  response accept
tl_a_valid/ready  out/in  NUM_LANES  A handshake
tl_a_opcode  out  3*NUM_LANES  Get=4, PutFull=0, PutPartial=1
tl_a_size  out  4*NUM_LANES  constant log2(DATA_WIDTH/8)
tl_a_source  out  SRC_WIDTH*NUM_LANES  slot index
tl_a_address  out  ADDR_WIDTH*NUM_LANES  {addr, OFS zeros}
tl_a_mask  out  (DATA_WIDTH/8)*NUM_LANES  byteen
tl_a_data  out  DATA_WIDTH*NUM_LANES  write data
tl_d_valid  in  NUM_LANES  D valid
tl_d_opcode  in  3*NUM_LANES  AccessAck=0, AccessAckData=1
tl_d_source  in  SRC_WIDTH*NUM_LANES  returned slot
tl_d_data  in  DATA_WIDTH*NUM_LANES  read data
tl_d_denied/corrupt  in  NUM_LANES  error bits
tl_d_ready  out  NUM_LANES  tied high once out of reset
err_sticky  out  1  sticky protocol/denied error

Behaviour:
- Clock and reset: single clock; reset_n is asynchronous, active-low. All state clears on reset: slots FREE, core_rsp_valid=0, err_sticky=0, core_req_ready=0, tl_a_valid=0, tl_d_ready=0.
- Slot states: FREE -> PEND on issue. PEND -> DONE when the received mask equals the issued mask. DONE -> FREE when its response is accepted, or immediately for a write-only slot, which produces no core response.
- Slot contents: tag, issued mask, read mask, received mask, NUM_LANES data words.
- Issue (atomic):
  - core_req_ready = any FREE slot AND tl_a_ready set for every lane with core_req_valid; otherwise all ready bits are 0.
  - On fire, the lowest-index FREE slot is allocated and tl_a_valid = core_req_valid in the same cycle, combinational; no partial issue.
  - Opcode per lane: rw=0 gives Get; rw=1 with all byteen set gives PutFull; otherwise PutPartial.
- D channel:
  - tl_d_ready is always 1, because storage is pre-reserved per slot.
  - Each beat sets received[lane] and stores data if the opcode is AccessAckData.
  - A beat whose source is not PEND, or whose lane bit is already received, sets err_sticky and is dropped.
  - denied or corrupt sets err_sticky; the beat still counts as received.
  - Beats on several lanes in the same cycle, for the same or different slots, are all absorbed.
- Response:
  - A single output register is loaded from the lowest-index DONE slot with a nonzero read mask whenever the register is empty, or is being accepted this cycle. Back-to-back responses run at 1/cycle.
  - Latency: last D beat at cycle N gives core_rsp_valid at N+1.
  - Outputs stay stable while valid && !ready.
  - A slot freed in cycle N is allocatable in N+1, never in N.
- Full: with NUM_SLOTS PEND/DONE slots, core_req_ready=0 until one frees.
- Reset mid-operation: in-flight TileLink responses after reset are treated as stray and flag err_sticky. The bench must quiesce before releasing reset.

Optional Feature:
- VX_TL_ADAPTER_PERF_EN defined: adds outputs perf_reqs (32b, issued requests), perf_stalls (32b, cycles with any core_req_valid && !core_req_ready) and perf_max_occ (log2(NUM_SLOTS)+1 bits, peak busy slots). All saturate and reset to 0.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package vx_tl_pkg holds:
  - TileLink opcode constants: TL_GET, TL_PUT_FULL, TL_PUT_PARTIAL, TL_ACCESS_ACK, TL_ACCESS_ACK_DATA.
  - slot_state_e enum: FREE/PEND/DONE.
  - Lowest-set-bit priority function.
- Sub-module vx_tl_slot_table: slot storage, allocate/receive/free logic and the DONE priority pick. The top holds the issue logic and the response register.

Test Plan:
- Read all lanes: valid=4'hF, rw=0, addr=0x100..0x103, tag=0x2A. Expect a_address 0x400,0x404,0x408,0x40C, opcode 4, source 0. D returns lanes in order 3,1,0,2 with data 0xA0..0xA3. Expect one rsp with tag 0x2A, tmask 4'hF, data placed per lane, valid one cycle after the lane-2 beat.
- Mixed: lanes 0,1 write (byteen 4'hF and 4'h3), lanes 2,3 read. Expect opcodes 0,1,4,4. Expect rsp tmask 4'hC only after both AccessAcks have arrived.
- Write-only request, all lanes PutFull: no core response; slot reusable the cycle after the last ack.
- Fill all 8 slots with no D traffic: 9th request sees ready=0. Return one slot's beats: ready=1 two cycles later, new request gets source = freed slot.
- Backpressure: two slots DONE, core_rsp_ready=0 for 5 cycles. Expect stable lower-slot response, then both responses on consecutive cycles once ready=1.
- Stray D beat with source of a FREE slot, plus a denied beat: err_sticky=1 and held. Async reset_n low mid-burst clears everything immediately.
